// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source 2-entry FIFOs feeding one registered register-file write port.
// Define WB_RR_EN for round-robin arbitration; otherwise the lowest non-empty index wins.
module wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_wsel,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
  output logic                      WEN,
  output logic [ADDR_W-1:0]         wsel,
  output logic [DATA_W-1:0]         wdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [ADDR_W-1:0] fifo_wsel_q  [NUM_SRC][2];
  logic [DATA_W-1:0] fifo_wdata_q [NUM_SRC][2];
  logic [NUM_SRC-1:0] head_q;
  logic [NUM_SRC-1:0] tail_q;
  logic [1:0]         count_q [NUM_SRC];

  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  wsel_q, wsel_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_SRC-1:0] nonempty_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  logic               grant_s;
  logic [IDX_W-1:0]   grant_idx_s;

  // Handshake is taken from current occupancy only; x0 writes complete the handshake but are dropped.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i]  = (count_q[i] < 2'd2);
      nonempty_s[i] = (count_q[i] != 2'd0);
      push_s[i]     = src_valid[i] && (count_q[i] < 2'd2) &&
                      (src_wsel[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}});
    end
  end

`ifdef WB_RR_EN
  logic [IDX_W-1:0] last_grant_q;

  // Round-robin search beginning one past the last granted source.
  always_comb begin
    int cand;
    grant_s     = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_SRC;
      if (!grant_s && nonempty_s[cand]) begin
        grant_s     = 1'b1;
        grant_idx_s = IDX_W'(cand);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Pointer moves only when something is actually granted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant_q <= IDX_W'(NUM_SRC - 1);
    end else if (grant_s) begin
      last_grant_q <= grant_idx_s;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest non-empty index as the winner.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (nonempty_s[i]) begin
        grant_s     = 1'b1;
        grant_idx_s = IDX_W'(i);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end
`endif

  // Pop the granted head and form the next output triple; wsel/wdata hold when idle.
  always_comb begin
    pop_s   = {NUM_SRC{1'b0}};
    wen_d   = grant_s;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    if (grant_s) begin
      pop_s[grant_idx_s] = 1'b1;
      wsel_d  = fifo_wsel_q[grant_idx_s][head_q[grant_idx_s]];
      wdata_d = fifo_wdata_q[grant_idx_s][head_q[grant_idx_s]];
    end else begin
      pop_s = {NUM_SRC{1'b0}};
    end
  end

  // Payload storage needs no reset: count_q decides which slots are live.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_s[i]) begin
        fifo_wsel_q[i][tail_q[i]]  <= src_wsel[i*ADDR_W +: ADDR_W];
        fifo_wdata_q[i][tail_q[i]] <= src_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers/occupancy and the registered write port.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i] <= 2'd0;
      end
      head_q  <= {NUM_SRC{1'b0}};
      tail_q  <= {NUM_SRC{1'b0}};
      wen_q   <= 1'b0;
      wsel_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i] <= count_q[i] + {1'b0, push_s[i]} - {1'b0, pop_s[i]};
      end
      head_q  <= head_q ^ pop_s;
      tail_q  <= tail_q ^ push_s;
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
    end
  end

  assign WEN   = wen_q;
  assign wsel  = wsel_q;
  assign wdata = wdata_q;
  assign busy  = (|nonempty_s) || wen_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
// Honors WB_RR_EN the same way the design does.
module tb_wb_arbiter;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*AW-1:0] src_wsel;
  logic [NS*DW-1:0] src_wdata;
  logic             WEN;
  logic [AW-1:0]    wsel;
  logic [DW-1:0]    wdata;
  logic             busy;

  wb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_wsel(src_wsel), .src_wdata(src_wdata),
    .WEN(WEN), .wsel(wsel), .wdata(wdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq [NS][$];
  int            m_last;
  logic          m_wen;
  logic [AW-1:0] m_wsel;
  logic [DW-1:0] m_wdata;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_last  = NS - 1;
    m_wen   = 1'b0;
    m_wsel  = '0;
    m_wdata = '0;
  endtask

  function automatic logic model_busy();
    logic b;
    b = m_wen;
    for (int i = 0; i < NS; i++) if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_valid[i]          = v;
    src_wsel[i*AW +: AW]  = a;
    src_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_wsel  = '0;
    src_wdata = '0;
  endtask

  // One clock: predict with the model, advance, compare outputs just after the edge.
  task automatic cycle();
    bit   acc [NS];
    int   g;
    ent_t e;
    for (int i = 0; i < NS; i++) begin
      check_eq($sformatf("ready%0d", i), 64'(src_ready[i]), 64'(mq[i].size() < 2));
      acc[i] = src_valid[i] && (mq[i].size() < 2);
    end
    g = -1;
`ifdef WB_RR_EN
    for (int k = 1; k <= NS; k++) begin
      int j;
      j = (m_last + k) % NS;
      if (g < 0 && mq[j].size() > 0) g = j;
    end
`else
    for (int j = 0; j < NS; j++) if (g < 0 && mq[j].size() > 0) g = j;
`endif
    if (g >= 0) begin
      e       = mq[g].pop_front();
      m_wen   = 1'b1;
      m_wsel  = e.a;
      m_wdata = e.d;
      m_last  = g;
    end else begin
      m_wen = 1'b0;
    end
    for (int i = 0; i < NS; i++)
      if (acc[i] && src_wsel[i*AW +: AW] != '0)
        mq[i].push_back({src_wsel[i*AW +: AW], src_wdata[i*DW +: DW]});
    @(posedge CLK);
    #1;
    check_eq("wen", 64'(WEN), 64'(m_wen));
    check_eq("wsel", 64'(wsel), 64'(m_wsel));
    check_eq("wdata", 64'(wdata), 64'(m_wdata));
    check_eq("busy", 64'(busy), 64'(model_busy()));
  endtask

  task automatic reset_dut();
    #2 nRST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic fill_all_two();
    for (int n = 0; n < 2; n++) begin
      for (int s = 0; s < NS; s++) set_src(s, 1'b1, AW'(s + 1), DW'(s * 16 + n));
      cycle();
    end
    clear_src();
  endtask

  int exp_src [6];
  int seen [$];
  int sent;
  bit acc2;

  initial begin
    clear_src();
    model_reset();
    #12 nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("rst_wen", 64'(WEN), 64'd0);
    check_eq("rst_wsel", 64'(wsel), 64'd0);
    check_eq("rst_wdata", 64'(wdata), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(src_ready), 64'(3'b111));

    // Single write from source 1: visible for exactly one cycle, two edges after acceptance.
    set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    clear_src();
    check_eq("single_early", 64'(WEN), 64'd0);
    cycle();
    check_eq("single_wen", 64'(WEN), 64'd1);
    check_eq("single_wsel", 64'(wsel), 64'd5);
    check_eq("single_wdata", 64'(wdata), 64'hDEADBEEF);
    cycle();
    check_eq("single_off", 64'(WEN), 64'd0);
    check_eq("single_busy", 64'(busy), 64'd0);

    // Register 0 writes are swallowed.
    set_src(0, 1'b1, 5'd0, 32'h1234);
    cycle();
    clear_src();
    check_eq("x0_ready", 64'(src_ready[0]), 64'd1);
    check_eq("x0_busy", 64'(busy), 64'd0);
    cycle();
    check_eq("x0_wen", 64'(WEN), 64'd0);

    // Arbitration order with every source loaded.
    reset_dut();
`ifdef WB_RR_EN
    exp_src = '{0, 1, 2, 0, 1, 2};
`else
    exp_src = '{0, 0, 1, 1, 2, 2};
`endif
    fill_all_two();
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("arb_wen%0d", k), 64'(WEN), 64'd1);
      check_eq($sformatf("arb_src%0d", k), 64'(wdata[7:4]), 64'(exp_src[k]));
      if (k < 5) cycle();
    end
    cycle();
    check_eq("arb_drained", 64'(busy), 64'd0);

    // Backpressure on source 2 while sources 0/1 keep the port busy.
    reset_dut();
    sent = 0;
    seen.delete();
    for (int c = 0; c < 40; c++) begin
      set_src(0, c < 8, 5'd1, $urandom);
      set_src(1, c < 8, 5'd2, $urandom);
      set_src(2, sent < 3, 5'd7, DW'(32'hA + sent));
      acc2 = src_valid[2] && src_ready[2];
      cycle();
      if (acc2) sent++;
      if (WEN && wsel == 5'd7) seen.push_back(int'(wdata));
    end
    clear_src();
    check_eq("bp_count", 64'(seen.size()), 64'd3);
    for (int k = 0; k < seen.size() && k < 3; k++)
      check_eq($sformatf("bp_data%0d", k), 64'(seen[k]), 64'(32'hA + k));

    // Asynchronous reset with entries pending and WEN high.
    reset_dut();
    fill_all_two();
    cycle();
    check_eq("mid_pre_wen", 64'(WEN), 64'd1);
    #2 nRST = 1'b0;
    #1;
    check_eq("mid_wen", 64'(WEN), 64'd0);
    check_eq("mid_busy", 64'(busy), 64'd0);
    check_eq("mid_ready", 64'(src_ready), 64'(3'b111));
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NS; s++)
        set_src(s, ($urandom % 3) != 0,
                (($urandom % 6) == 0) ? 5'd0 : AW'($urandom_range(1, 31)), $urandom);
      cycle();
    end
    clear_src();
    for (int k = 0; k < 8; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
